vend_sequencer: RTL and testbench

Central controller for the vending machine: accepts single-cycle coin pulses, tracks credit in nickel units and gates the vend, and sequences the product dispense and change payout as timed pulses. Sits between the synchronized/edge-detected button inputs and the LED/actuator outputs in top.

---
 rtl/vend_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_vend_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending controller: coin credit, vend gating, timed dispense and change pulses
// Optional macro CHANGE_DIME_EN: pay change in dimes while credit >= 2, nickels otherwise.
module vend_sequencer #(
  parameter int PRICE_N      = 5,
  parameter int MAX_N        = 15,
  parameter int CREDIT_W     = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nickel,
  input  logic                dime,
  input  logic                dispense_btn,
  input  logic                cancel,
  output logic                locked_led,
  output logic                dispense_led,
  output logic                change,
  output logic                change_dime,
  output logic                coin_reject,
  output logic                req_deny,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int T_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0]       PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0]       GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE_N);
  localparam logic [CREDIT_W:0]   MAX_C      = (CREDIT_W + 1)'(MAX_N);

`ifdef CHANGE_DIME_EN
  localparam bit DIME_PAY = 1'b1;
`else
  localparam bit DIME_PAY = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                gap_q, gap_d;
  logic                locked_led_q, locked_led_d;
  logic                dispense_led_q, dispense_led_d;
  logic                change_q, change_d;
  logic                change_dime_q, change_dime_d;
  logic                coin_reject_q, coin_reject_d;
  logic                req_deny_q, req_deny_d;
  logic                busy_q, busy_d;

  logic                grant;
  logic                start_pay;
  logic [CREDIT_W:0]   coin_sum;

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    timer_d        = timer_q;
    gap_d          = gap_q;
    dispense_led_d = dispense_led_q;
    change_d       = change_q;
    change_dime_d  = change_dime_q;
    coin_reject_d  = 1'b0;
    req_deny_d     = 1'b0;
    grant          = 1'b0;
    start_pay      = 1'b0;
    // A dime takes precedence over a simultaneous nickel
    coin_sum       = {1'b0, credit_q} + (CREDIT_W + 1)'(dime ? 2 : 1);

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel) begin
          if (state_q == S_CREDIT) start_pay = 1'b1;
        end else if (dispense_btn) begin
          if (credit_q >= PRICE_C) begin
            grant          = 1'b1;
            state_d        = S_VEND;
            credit_d       = credit_q - PRICE_C;
            dispense_led_d = 1'b1;
            timer_d        = '0;
          end else begin
            req_deny_d = 1'b1;
          end
        end

        if (nickel || dime) begin
          if (grant || start_pay || (coin_sum > MAX_C)) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            if (nickel && dime) coin_reject_d = 1'b1;
          end
        end

        if (!grant && !start_pay) state_d = (credit_d == '0) ? S_IDLE : S_CREDIT;
      end

      S_VEND: begin
        coin_reject_d = nickel | dime;
        if (timer_q == PULSE_LAST) begin
          dispense_led_d = 1'b0;
          timer_d        = '0;
          if (credit_q != '0) start_pay = 1'b1;
          else                state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_CHANGE: begin
        coin_reject_d = nickel | dime;
        if (!gap_q) begin
          if (timer_q == PULSE_LAST) begin
            change_d      = 1'b0;
            change_dime_d = 1'b0;
            gap_d         = 1'b1;
            timer_d       = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else begin
          if (timer_q == GAP_LAST) begin
            gap_d   = 1'b0;
            timer_d = '0;
            if (credit_q == '0) state_d   = S_IDLE;
            else                start_pay = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Each payout pulse takes its coin off the credit on its first cycle
    if (start_pay) begin
      state_d = S_CHANGE;
      gap_d   = 1'b0;
      timer_d = '0;
      if (DIME_PAY && (credit_q >= CREDIT_W'(2))) begin
        change_dime_d = 1'b1;
        credit_d      = credit_q - CREDIT_W'(2);
      end else begin
        change_d = 1'b1;
        credit_d = credit_q - CREDIT_W'(1);
      end
    end

    locked_led_d = (credit_d < PRICE_C);
    busy_d       = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      timer_q        <= '0;
      gap_q          <= 1'b0;
      locked_led_q   <= 1'b1;
      dispense_led_q <= 1'b0;
      change_q       <= 1'b0;
      change_dime_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      req_deny_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      gap_q          <= gap_d;
      locked_led_q   <= locked_led_d;
      dispense_led_q <= dispense_led_d;
      change_q       <= change_d;
      change_dime_q  <= change_dime_d;
      coin_reject_q  <= coin_reject_d;
      req_deny_q     <= req_deny_d;
      busy_q         <= busy_d;
    end
  end

  assign locked_led   = locked_led_q;
  assign dispense_led = dispense_led_q;
  assign change       = change_q;
  assign change_dime  = change_dime_q;
  assign coin_reject  = coin_reject_q;
  assign req_deny     = req_deny_q;
  assign busy         = busy_q;
  assign credit       = credit_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed self-checking bench for vend_sequencer
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       nickel, dime, dispense_btn, cancel;
  logic       locked_led, dispense_led, change, change_dime;
  logic       coin_reject, req_deny, busy;
  logic [3:0] credit;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vend_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .nickel       (nickel),
    .dime         (dime),
    .dispense_btn (dispense_btn),
    .cancel       (cancel),
    .locked_led   (locked_led),
    .dispense_led (dispense_led),
    .change       (change),
    .change_dime  (change_dime),
    .coin_reject  (coin_reject),
    .req_deny     (req_deny),
    .busy         (busy),
    .credit       (credit)
  );

  // Inputs are held for one cycle from a falling edge; outputs are read at the next falling edge.
  task automatic apply(input logic n, input logic d, input logic b, input logic c);
    nickel = n; dime = d; dispense_btn = b; cancel = c;
    @(negedge clk);
    nickel = 0; dime = 0; dispense_btn = 0; cancel = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    nickel = 0; dime = 0; dispense_btn = 0; cancel = 0;
    do_reset();
    n_cmp++;
    if ({dispense_led, change, change_dime, coin_reject, req_deny, busy} !== 6'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 000000",
                        {dispense_led, change, change_dime, coin_reject, req_deny, busy});
    end
    n_cmp++;
    if (locked_led !== 1'b1 || credit !== 4'd0) begin
      n_bad++; $display("FAIL reset_credit: got locked=%b credit=%0d want locked=1 credit=0", locked_led, credit);
    end
  endtask

  task automatic test_coins_vend();
    int cnt;
    logic chg_seen;
    do_reset();
    apply(1, 0, 0, 0);
    n_cmp++;
    if (credit !== 4'd1 || locked_led !== 1'b1) begin
      n_bad++; $display("FAIL nickel: got credit=%0d locked=%b want 1/1", credit, locked_led);
    end
    apply(0, 1, 0, 0);
    n_cmp++;
    if (credit !== 4'd3 || locked_led !== 1'b1) begin
      n_bad++; $display("FAIL dime1: got credit=%0d locked=%b want 3/1", credit, locked_led);
    end
    apply(0, 1, 0, 0);
    n_cmp++;
    if (credit !== 4'd5 || locked_led !== 1'b0) begin
      n_bad++; $display("FAIL dime2_unlock: got credit=%0d locked=%b want 5/0", credit, locked_led);
    end
    apply(0, 0, 1, 0);
    n_cmp++;
    if (credit !== 4'd0 || busy !== 1'b1 || locked_led !== 1'b1) begin
      n_bad++; $display("FAIL vend_grant: got credit=%0d busy=%b locked=%b want 0/1/1", credit, busy, locked_led);
    end
    cnt = 0; chg_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (change || change_dime) chg_seen = 1;
      if (!dispense_led) break;
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 4) begin
      n_bad++; $display("FAIL dispense_len: got %0d want 4", cnt);
    end
    n_cmp++;
    if (busy !== 1'b0 || chg_seen !== 1'b0 || change !== 1'b0) begin
      n_bad++; $display("FAIL vend_to_idle: got busy=%b chg_seen=%b want 0/0", busy, chg_seen);
    end
  endtask

  task automatic test_vend_change();
    int cnt;
    do_reset();
    apply(0, 1, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 1, 0, 0);
    n_cmp++;
    if (credit !== 4'd6) begin
      n_bad++; $display("FAIL three_dimes: got %0d want 6", credit);
    end
    apply(0, 0, 1, 0);
    n_cmp++;
    if (credit !== 4'd1 || dispense_led !== 1'b1) begin
      n_bad++; $display("FAIL grant6: got credit=%0d disp=%b want 1/1", credit, dispense_led);
    end
    cnt = 0;
    for (int i = 0; i < 20 && dispense_led; i++) begin
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 4 || change !== 1'b1 || credit !== 4'd0) begin
      n_bad++; $display("FAIL change_start: got disp_len=%0d change=%b credit=%0d want 4/1/0", cnt, change, credit);
    end
    cnt = 0;
    for (int i = 0; i < 20 && change; i++) begin
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 4) begin
      n_bad++; $display("FAIL change_len: got %0d want 4", cnt);
    end
    cnt = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      if (change) cnt = 100;
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 4 || busy !== 1'b0 || credit !== 4'd0) begin
      n_bad++; $display("FAIL gap_len: got %0d busy=%b credit=%0d want 4/0/0", cnt, busy, credit);
    end
  endtask

  task automatic test_deny();
    do_reset();
    apply(1, 0, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 0, 1, 0);
    n_cmp++;
    if (req_deny !== 1'b1 || credit !== 4'd3 || locked_led !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL deny: got deny=%b credit=%0d locked=%b busy=%b want 1/3/1/0",
                        req_deny, credit, locked_led, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (req_deny !== 1'b0 || dispense_led !== 1'b0) begin
      n_bad++; $display("FAIL deny_one_cycle: got deny=%b disp=%b want 0/0", req_deny, dispense_led);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 7; i++) apply(0, 1, 0, 0);
    n_cmp++;
    if (credit !== 4'd14 || coin_reject !== 1'b0) begin
      n_bad++; $display("FAIL credit14: got credit=%0d rej=%b want 14/0", credit, coin_reject);
    end
    apply(0, 1, 0, 0);
    n_cmp++;
    if (credit !== 4'd14 || coin_reject !== 1'b1) begin
      n_bad++; $display("FAIL dime_over: got credit=%0d rej=%b want 14/1", credit, coin_reject);
    end
    apply(1, 0, 0, 0);
    n_cmp++;
    if (credit !== 4'd15 || coin_reject !== 1'b0) begin
      n_bad++; $display("FAIL nickel_to_max: got credit=%0d rej=%b want 15/0", credit, coin_reject);
    end
    apply(1, 0, 0, 0);
    n_cmp++;
    if (credit !== 4'd15 || coin_reject !== 1'b1) begin
      n_bad++; $display("FAIL nickel_over: got credit=%0d rej=%b want 15/1", credit, coin_reject);
    end
    do_reset();
    apply(1, 1, 0, 0);
    n_cmp++;
    if (credit !== 4'd2 || coin_reject !== 1'b1) begin
      n_bad++; $display("FAIL both_coins: got credit=%0d rej=%b want 2/1", credit, coin_reject);
    end
    @(negedge clk);
    n_cmp++;
    if (coin_reject !== 1'b0 || credit !== 4'd2) begin
      n_bad++; $display("FAIL reject_one_cycle: got rej=%b credit=%0d want 0/2", coin_reject, credit);
    end
  endtask

  task automatic test_busy_reject();
    do_reset();
    apply(0, 1, 0, 0);
    apply(0, 1, 0, 0);
    apply(1, 0, 0, 0);
    apply(0, 0, 1, 0);
    apply(1, 0, 1, 1);
    n_cmp++;
    if (coin_reject !== 1'b1 || req_deny !== 1'b0 || credit !== 4'd0 || dispense_led !== 1'b1) begin
      n_bad++; $display("FAIL busy_coin: got rej=%b deny=%b credit=%0d disp=%b want 1/0/0/1",
                        coin_reject, req_deny, credit, dispense_led);
    end
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || change !== 1'b0 || credit !== 4'd0) begin
      n_bad++; $display("FAIL busy_drain: got busy=%b change=%b credit=%0d want 0/0/0", busy, change, credit);
    end
  endtask

  task automatic test_cancel_refund();
    int k;
    int ns;
    logic hi, exp_chg, exp_dime;
    logic [3:0] exp_credit;
    do_reset();
    apply(0, 1, 0, 0);
    apply(0, 1, 0, 0);
    apply(1, 0, 0, 0);
    apply(0, 0, 0, 1);
`ifdef CHANGE_DIME_EN
    ns = 24;
`else
    ns = 40;
`endif
    for (int i = 0; i < ns; i++) begin
      k  = i / 8;
      hi = ((i % 8) < 4);
`ifdef CHANGE_DIME_EN
      exp_dime   = hi && (k < 2);
      exp_chg    = hi && (k == 2);
      exp_credit = (k == 0) ? 4'd3 : (k == 1) ? 4'd1 : 4'd0;
`else
      exp_dime   = 1'b0;
      exp_chg    = hi;
      exp_credit = 4'(4 - k);
`endif
      n_cmp++;
      if ({change, change_dime, busy, credit} !== {exp_chg, exp_dime, 1'b1, exp_credit}) begin
        n_bad++; $display("FAIL refund_seq[%0d]: got chg=%b dime=%b busy=%b credit=%0d want %b/%b/1/%0d",
                          i, change, change_dime, busy, credit, exp_chg, exp_dime, exp_credit);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (busy !== 1'b0 || credit !== 4'd0 || change !== 1'b0 || locked_led !== 1'b1) begin
      n_bad++; $display("FAIL refund_end: got busy=%b credit=%0d change=%b locked=%b want 0/0/0/1",
                        busy, credit, change, locked_led);
    end
  endtask

  task automatic test_reset_mid_vend();
    do_reset();
    apply(0, 1, 0, 0);
    apply(0, 1, 0, 0);
    apply(1, 0, 0, 0);
    apply(0, 0, 1, 0);
    @(negedge clk);
    n_cmp++;
    if (dispense_led !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_vend_setup: got disp=%b busy=%b want 1/1", dispense_led, busy);
    end
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if ({dispense_led, change, change_dime, coin_reject, req_deny, busy, locked_led, credit} !== {7'b0000001, 4'd0}) begin
      n_bad++; $display("FAIL mid_vend_reset: got disp=%b chg=%b busy=%b locked=%b credit=%0d want 0/0/0/1/0",
                        dispense_led, change, busy, locked_led, credit);
    end
    rst = 1;
    apply(1, 0, 0, 0);
    n_cmp++;
    if (credit !== 4'd1 || coin_reject !== 1'b0 || dispense_led !== 1'b0) begin
      n_bad++; $display("FAIL after_reset_coin: got credit=%0d rej=%b disp=%b want 1/0/0", credit, coin_reject, dispense_led);
    end
  endtask

  initial begin
    rst = 0;
    nickel = 0; dime = 0; dispense_btn = 0; cancel = 0;
    @(negedge clk);
    test_reset();
    test_coins_vend();
    test_vend_change();
    test_deny();
    test_saturate();
    test_busy_reject();
    test_cancel_refund();
    test_reset_mid_vend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule
